// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state encodings, mux codes and control-word type for the multicycle controller
package mc_ctrl_pkg;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JAL    = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_4    = 2'd1;
    localparam logic [1:0] SRCB_SE   = 2'd2;
    localparam logic [1:0] SRCB_SESH = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } ctrl_t;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state-to-control-word decode
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   bne_i,
    input  logic   mem_ok_i,
    output ctrl_t  ctrl_o
);
    // Moore decode; the fetch write-enables wait for the memory to deliver the instruction
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_4;
                ctrl_o.ir_write  = mem_ok_i;
                ctrl_o.pc_write  = mem_ok_i;
            end
            S_DECODE: ctrl_o.alu_src_b = SRCB_SESH;
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SE;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.memto_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = RD_RD;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PC_ALUOUT;
                ctrl_o.branch_ne     = bne_i;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PC_JUMP;
            end
            S_ADDIWB: ctrl_o.reg_write = 1'b1;
            S_JAL: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PC_JUMP;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = RD_R31;
            end
            S_TRAP: ctrl_o.trap = 1'b1;
            default: ctrl_o = '0;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle CPU control FSM with memory handshake, hold, trap and retire counter
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_EN       = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       Opcode,
    input  logic             MemReady,
    input  logic             Hold,
    output logic [3:0]       State,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Trap,
    output logic [CNT_W-1:0] InstrCount
);
    state_e           state_q, state_d;
    logic             bne_q, bne_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_ok, stall;
    ctrl_t            raw, ctl;

    assign mem_ok = MemReady || !MEM_HANDSHAKE;
    assign stall  = Hold || (!mem_ok && state_q inside {S_FETCH, S_MEMRD, S_MEMWR});

    // Next state, branch flavour capture and retire count; everything freezes while stalled
    always_comb begin
        state_d = state_q;
        bne_d   = bne_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    bne_d = Opcode == OP_BNE;
                    case (Opcode)
                        OP_LW, OP_SW:   state_d = S_MEMADR;
                        OP_R:           state_d = S_EXEC;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        OP_ADDI:        state_d = S_ADDIEX;
                        OP_JAL:         state_d = S_JAL;
                        default:        state_d = TRAP_EN ? S_TRAP : S_FETCH;
                    endcase
                end
                S_MEMADR: state_d = Opcode == OP_SW ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_d = S_MEMWB;
                S_EXEC:   state_d = S_ALUWB;
                S_ADDIEX: state_d = S_ADDIWB;
                S_TRAP:   state_d = S_TRAP;
                S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB, S_JAL: begin
                    state_d = S_FETCH;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                default:  state_d = S_FETCH;
            endcase
        end
    end

    // State, branch flag and counter registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_FETCH;
            bne_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bne_q   <= bne_d;
            cnt_q   <= cnt_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i  (state_q),
        .bne_i    (bne_q),
        .mem_ok_i (mem_ok),
        .ctrl_o   (raw)
    );

    // Reset silences every output; Hold suppresses only state-changing write enables
    always_comb begin
        ctl = Reset ? '0 : raw;
        if (Hold) begin
            ctl.mem_write     = 1'b0;
            ctl.reg_write     = 1'b0;
            ctl.pc_write      = 1'b0;
            ctl.pc_write_cond = 1'b0;
            ctl.ir_write      = 1'b0;
        end
    end

    assign State       = state_q;
    assign InstrCount  = cnt_q;
    assign PCWrite     = ctl.pc_write;
    assign PCWriteCond = ctl.pc_write_cond;
    assign BranchNe    = ctl.branch_ne;
    assign IorD        = ctl.iord;
    assign MemRead     = ctl.mem_read;
    assign MemWrite    = ctl.mem_write;
    assign IRWrite     = ctl.ir_write;
    assign MemtoReg    = ctl.memto_reg;
    assign ALUSrcA     = ctl.alu_src_a;
    assign RegWrite    = ctl.reg_write;
    assign RegDst      = ctl.reg_dst;
    assign ALUSrcB     = ctl.alu_src_b;
    assign ALUOp       = ctl.alu_op;
    assign PCSource    = ctl.pc_source;
    assign Trap        = ctl.trap;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized scoreboard bench for two configurations of the multicycle controller
module tb_mc_ctrl_fsm;
    logic        Clk = 1'b0;
    logic        Reset, Hold, MemReady;
    logic [5:0]  op [2];
    logic [3:0]  st0, st1;
    logic [18:0] o0, o1;
    logic [15:0] c0;
    logic [1:0]  c1;

    int checks = 0;
    int errors = 0;

    logic [38:0] q0[$], q1[$];

    int  seq [2][3];
    int  len [2], pos [2], cur [2], cnt [2];
    bit  bne [2];

    always #5 Clk = ~Clk;

    mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_EN(1'b1), .CNT_W(16)) dut0 (
        .Clk(Clk), .Reset(Reset), .Opcode(op[0]), .MemReady(MemReady), .Hold(Hold), .State(st0),
        .PCWrite(o0[18]), .PCWriteCond(o0[17]), .BranchNe(o0[16]), .IorD(o0[15]), .MemRead(o0[14]),
        .MemWrite(o0[13]), .IRWrite(o0[12]), .MemtoReg(o0[11]), .ALUSrcA(o0[10]), .RegWrite(o0[9]),
        .RegDst(o0[8:7]), .ALUSrcB(o0[6:5]), .ALUOp(o0[4:3]), .PCSource(o0[2:1]), .Trap(o0[0]),
        .InstrCount(c0)
    );

    mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b0), .TRAP_EN(1'b0), .CNT_W(2)) dut1 (
        .Clk(Clk), .Reset(Reset), .Opcode(op[1]), .MemReady(MemReady), .Hold(Hold), .State(st1),
        .PCWrite(o1[18]), .PCWriteCond(o1[17]), .BranchNe(o1[16]), .IorD(o1[15]), .MemRead(o1[14]),
        .MemWrite(o1[13]), .IRWrite(o1[12]), .MemtoReg(o1[11]), .ALUSrcA(o1[10]), .RegWrite(o1[9]),
        .RegDst(o1[8:7]), .ALUSrcB(o1[6:5]), .ALUOp(o1[4:3]), .PCSource(o1[2:1]), .Trap(o1[0]),
        .InstrCount(c1)
    );

    function automatic logic [18:0] exp_out(int s, bit bn_i, bit mr_ok, bit hold, bit rst);
        logic pcw = 0, pcwc = 0, bn = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, asa = 0, rw = 0, trap = 0;
        logic [1:0] rd = 0, asb = 0, aop = 0, pcs = 0;
        case (s)
            0:  begin mrd = 1; asb = 1; irw = mr_ok; pcw = mr_ok; end
            1:  asb = 3;
            2:  begin asa = 1; asb = 2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 1; pcwc = 1; pcs = 1; bn = bn_i; end
            9:  begin pcw = 1; pcs = 2; end
            10: begin asa = 1; asb = 2; end
            11: rw = 1;
            12: begin pcw = 1; pcs = 2; rw = 1; rd = 2; end
            13: trap = 1;
            default: ;
        endcase
        if (hold) {mwr, rw, pcw, pcwc, irw} = 5'b0;
        return rst ? 19'b0 : {pcw, pcwc, bn, iord, mrd, mwr, irw, m2r, asa, rw, rd, asb, aop, pcs, trap};
    endfunction

    task automatic load(int i, int a, int b, int c, int n);
        seq[i][0] = a; seq[i][1] = b; seq[i][2] = c;
        len[i] = n; pos[i] = 0; cur[i] = a;
    endtask

    // Instruction-level model: each opcode expands to its list of post-decode states
    task automatic step(int i, bit hs, bit te, int w);
        if (Reset) begin
            cur[i] = 0; cnt[i] = 0;
        end else if (Hold || (hs && !MemReady && cur[i] inside {0, 3, 5}) || cur[i] == 13) begin
        end else if (cur[i] == 0) begin
            cur[i] = 1;
        end else if (cur[i] == 1) begin
            bne[i] = op[i] == 6'b000101;
            case (op[i])
                6'b100011:            load(i, 2, 3, 4, 3);
                6'b101011:            load(i, 2, 5, 0, 2);
                6'b000000:            load(i, 6, 7, 0, 2);
                6'b000100, 6'b000101: load(i, 8, 0, 0, 1);
                6'b000010:            load(i, 9, 0, 0, 1);
                6'b001000:            load(i, 10, 11, 0, 2);
                6'b000011:            load(i, 12, 0, 0, 1);
                default:              cur[i] = te ? 13 : 0;
            endcase
        end else begin
            pos[i]++;
            if (pos[i] == len[i]) begin
                cur[i] = 0;
                cnt[i] = (cnt[i] + 1) % (1 << w);
            end else cur[i] = seq[i][pos[i]];
        end
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] legal [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                  6'b000101, 6'b001000, 6'b000010, 6'b000011};
        int r = $urandom_range(0, 19);
        return r < 18 ? legal[r % 8] : 6'($urandom);
    endfunction

    task automatic check(int i, logic [38:0] e, logic [38:0] a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL dut%0d t=%0t state got %0d exp %0d ctl got %h exp %h count got %0d exp %0d",
                     i, $time, a[38:35], e[38:35], a[34:16], e[34:16], a[15:0], e[15:0]);
        end
    endtask

    // Monitor: every cycle the DUTs present a control word, compared against the queued expectation
    always @(negedge Clk) begin
        if (q0.size() > 0) check(0, q0.pop_front(), {st0, o0, c0});
        if (q1.size() > 0) check(1, q1.pop_front(), {st1, o1, 14'b0, c1});
    end

    initial begin
        Reset = 1'b1; Hold = 1'b0; MemReady = 1'b1;
        op[0] = 6'b0; op[1] = 6'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge Clk);
            step(0, 1'b1, 1'b1, 16);
            step(1, 1'b0, 1'b0, 2);
            #1;
            Reset    = c < 2 || $urandom_range(0, 59) == 0;
            Hold     = $urandom_range(0, 5) == 0;
            MemReady = $urandom_range(0, 2) != 0;
            for (int i = 0; i < 2; i++)
                if (cur[i] != 1 && cur[i] != 2) op[i] = rand_op();
            q0.push_back({4'(cur[0]), exp_out(cur[0], bne[0], MemReady, Hold, Reset), 16'(cnt[0])});
            q1.push_back({4'(cur[1]), exp_out(cur[1], bne[1], 1'b1, Hold, Reset), 16'(cnt[1])});
        end
        @(posedge Clk);
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL drain leftover got %0d exp 0", q0.size() + q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multicycle control unit for the CPU datapath: a Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It extends the base five-instruction FSM with ADDI, BNE and JAL support, a memory-ready handshake, a pipeline hold input, an illegal-opcode trap and a retired-instruction counter. It drives all datapath control strobes directly.

Parameters:
MEM_HANDSHAKE, 1, 1 = FETCH/MEMRD/MEMWR wait for MemReady; 0 = single-cycle memory, MemReady ignored
TRAP_EN, 1, 1 = illegal opcode enters sticky TRAP; 0 = illegal opcode returns to FETCH (instruction skipped, not counted)
CNT_W, 16, width of retired-instruction counter

Ports:
Clk  in  1  clock, all state changes on rising edge
Reset  in  1  synchronous, active-high
Opcode  in  6  IR[31:26], valid from DECODE onward
MemReady  in  1  memory access complete this cycle
Hold  in  1  freeze FSM and counter
State  out  4  current state encoding
PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite  out  1 each  datapath strobes
RegDst  out  2  0=rt, 1=rd, 2=r31
ALUSrcB  out  2  0=B, 1=4, 2=signext, 3=signext<<2
ALUOp  out  2  0=add, 1=sub, 2=funct
PCSource  out  2  0=ALU, 1=ALUOut, 2=jump target
Trap  out  1  high in TRAP
InstrCount  out  CNT_W  retired-instruction count

Behaviour:
- Opcodes: LW 100011, SW 101011, R 000000, BEQ 000100, BNE 000101, ADDI 001000, J 000010, JAL 000011; all others illegal.
- States: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 ALUWB, 8 BRANCH, 9 JUMP, 10 ADDIEX, 11 ADDIWB, 12 JAL, 13 TRAP. Codes 14–15 go to FETCH on the next edge.
- Transitions: FETCH→DECODE. DECODE→ LW/SW:2, R:6, BEQ/BNE:8, J:9, ADDI:10, JAL:12, illegal: TRAP_EN ? 13 : 0. MEMADR→ LW:3, SW:5. 3→4, 6→7, 10→11. Terminal states 4, 5, 7, 8, 9, 11, 12 go to 0. TRAP→TRAP until Reset.
- Wait states: with MEM_HANDSHAKE=1, FETCH, MEMRD and MEMWR hold while MemReady=0 and advance on the edge where MemReady=1. Strobes repeat each wait cycle. IRWrite and PCWrite in FETCH are asserted only when MemReady=1.
- Priority per edge: Reset > Hold > MemReady wait > normal transition.
- Reset: State=0 and InstrCount=0 on the edge. While Reset=1 all 1-bit strobes and Trap are forced 0 and 2-bit outputs are forced 0. Reset mid-instruction abandons it with no count.
- Hold=1 freezes State and InstrCount and forces MemWrite, RegWrite, PCWrite, PCWriteCond and IRWrite to 0. Reads and muxes stay per state.
- Strobes are a pure Moore decode of State (zero latency), standard multicycle encoding. Additions over that encoding:
  - BRANCH: ALUOp=sub; PCWriteCond=1; BranchNe=1 only for BNE.
  - ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=add.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
  - JAL: PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=0. The link value is PC (already PC+4), selected by the datapath on RegDst=2.
- InstrCount increments by 1 on each edge leaving a terminal state to FETCH (not Hold). It wraps from 2^CNT_W−1 to 0 and does not saturate.
- Opcode is sampled only in DECODE and MEMADR. It need not be stable elsewhere.

Decomposition:
- Package mc_ctrl_pkg: opcode localparams, state encodings, ALUOp/PCSource/RegDst/ALUSrcB codes.
- Sub-module mc_ctrl_decode: combinational State→strobe decode, with Reset/Hold gating in the top level.
- Top level holds the state register, next-state logic and counter.

Test Plan:
- LW, MemReady=1, MEM_HANDSHAKE=1 → State 0,1,2,3,4,0; MemRead high in 0 and 3; RegWrite only in 4; InstrCount 0→1 on the 4→0 edge.
- SW with MemReady low 3 cycles in state 5 → State 0,1,2,5,5,5,5,0; MemWrite high for 4 cycles; count +1 once.
- BNE then JAL → states 0,1,8,0,1,12,0; BranchNe=1 only in 8; RegDst=2 and PCSource=2 in 12; InstrCount=2.
- Opcode 111111 with TRAP_EN=1 → 0,1,13,13…, Trap=1, count unchanged until Reset. With TRAP_EN=0 → 0,1,0, count unchanged.
- Reset asserted in state 3 → next edge State=0; strobes 0 while Reset high; InstrCount=0.
- Hold=1 for 2 cycles in state 7 → State stays 7, RegWrite=0, count frozen; on release RegWrite=1 then 0. With CNT_W=2 → counter wraps 3→0 after 4 instructions.
